// File: rtl/rom_program_loader.sv
// rom_program_loader
// ------------------
// Writer side of the processor's instruction store. A START pulse begins a
// load of LENGTH words. Each word accepted on the IN_VALID/IN_READY handshake
// is written straight through to the next sequential store address while a
// running checksum is kept. Once the whole image is written, every word is
// read back through the store's registered read port and summed. The
// processor stays in reset (CPU_HOLD) until the two checksums agree.
//
// Ports
//   CLK, RESET           rising-edge clock, asynchronous active-high reset
//   START, LENGTH        load request pulse and word count (0..2**addrBits)
//   IN_VALID, IN_DATA    incoming instruction stream
//   IN_READY             loader accepts a word this cycle
//   MEM_WREN             store write enable (combinational on handshake)
//   MEM_ADDRESS          shared write/read address
//   MEM_DATAIN           store write data
//   MEM_DATAOUT          store read data, valid one cycle after the address
//   BUSY, DONE, ERROR    registered status
//   CPU_HOLD             registered processor reset hold

module rom_program_loader #(
  parameter int width    = 9,
  parameter int depth    = 32,
  parameter int addrBits = 5
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic [addrBits:0]   LENGTH,
  input  logic                IN_VALID,
  input  logic [width-1:0]    IN_DATA,
  output logic                IN_READY,
  output logic                MEM_WREN,
  output logic [addrBits-1:0] MEM_ADDRESS,
  output logic [width-1:0]    MEM_DATAIN,
  input  logic [width-1:0]    MEM_DATAOUT,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERROR,
  output logic                CPU_HOLD
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [addrBits:0]   depthVal = (addrBits+1)'(depth);
  localparam logic [addrBits:0]   cntOne   = (addrBits+1)'(1);
  localparam logic [addrBits-1:0] ptrOne   = addrBits'(1);

  state_t              state_q;
  logic [addrBits-1:0] wptr_q;
  logic [addrBits:0]   rptr_q;
  logic [addrBits:0]   count_q;
  logic [addrBits:0]   len_q;
  logic [width-1:0]    wsum_q;
  logic [width-1:0]    rsum_q;
  logic                readIssued_q;
  logic                inReady_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic                cpuHold_q;

  logic                accept;
  logic                lastWord;
  logic                lastRead;
  logic [width-1:0]    wsum_d;
  logic [width-1:0]    rsum_d;

  // Handshake, next checksum values and end-of-phase detection. The final
  // read sum is compared using rsum_d so the decision lands on the same
  // cycle the last read data arrives, giving a VERIFY of exactly len+1 cycles.
  always_comb begin
    accept   = inReady_q & IN_VALID;
    wsum_d   = wsum_q + IN_DATA;
    rsum_d   = rsum_q + MEM_DATAOUT;
    lastWord = (count_q == (len_q - cntOne));
    lastRead = readIssued_q & (rptr_q == len_q);
  end

  // Store port: writes go straight through on the handshake, the read
  // address follows rptr during VERIFY and idles at 0 otherwise. When rptr
  // has reached len the address is a harmless dummy read that is never summed.
  always_comb begin
    MEM_WREN    = accept;
    MEM_DATAIN  = IN_DATA;
    MEM_ADDRESS = '0;
    if (state_q == S_LOAD)
      MEM_ADDRESS = wptr_q;
    else if (state_q == S_VERIFY)
      MEM_ADDRESS = rptr_q[addrBits-1:0];
  end

  // Control FSM with all status outputs registered alongside the state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      len_q        <= '0;
      wsum_q       <= '0;
      rsum_q       <= '0;
      readIssued_q <= 1'b0;
      inReady_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpuHold_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (START) begin
            if (LENGTH > depthVal) begin
              state_q   <= S_ERR;
              done_q    <= 1'b0;
              error_q   <= 1'b1;
              cpuHold_q <= 1'b1;
            end else if (LENGTH == '0) begin
              // Empty image: checksums trivially match.
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              error_q   <= 1'b0;
              cpuHold_q <= 1'b0;
            end else begin
              state_q   <= S_LOAD;
              len_q     <= LENGTH;
              wptr_q    <= '0;
              wsum_q    <= '0;
              count_q   <= '0;
              inReady_q <= 1'b1;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              error_q   <= 1'b0;
              cpuHold_q <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (accept) begin
            wsum_q  <= wsum_d;
            wptr_q  <= wptr_q + ptrOne;
            count_q <= count_q + cntOne;
            if (lastWord) begin
              state_q      <= S_VERIFY;
              rptr_q       <= '0;
              rsum_q       <= '0;
              readIssued_q <= 1'b0;
              inReady_q    <= 1'b0;
            end
          end
        end

        S_VERIFY: begin
          if (rptr_q < len_q) begin
            rptr_q       <= rptr_q + cntOne;
            readIssued_q <= 1'b1;
          end else begin
            readIssued_q <= 1'b0;
          end
          if (readIssued_q)
            rsum_q <= rsum_d;
          if (lastRead) begin
            busy_q <= 1'b0;
            if (rsum_d == wsum_q) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              cpuHold_q <= 1'b0;
            end else begin
              state_q   <= S_ERR;
              error_q   <= 1'b1;
              cpuHold_q <= 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign IN_READY = inReady_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERROR    = error_q;
  assign CPU_HOLD = cpuHold_q;

endmodule

// File: tb/tb_rom_program_loader.sv
// tb_rom_program_loader
// ---------------------
// Directed bench for rom_program_loader with a behavioural instruction store
// (registered read, optional corruption of address 1 on readback).

module tb_rom_program_loader;

  localparam int width    = 9;
  localparam int depth    = 32;
  localparam int addrBits = 5;

  logic                CLK = 1'b0;
  logic                RESET;
  logic                START;
  logic [addrBits:0]   LENGTH;
  logic                IN_VALID;
  logic [width-1:0]    IN_DATA;
  logic                IN_READY;
  logic                MEM_WREN;
  logic [addrBits-1:0] MEM_ADDRESS;
  logic [width-1:0]    MEM_DATAIN;
  logic [width-1:0]    MEM_DATAOUT;
  logic                BUSY;
  logic                DONE;
  logic                ERROR;
  logic                CPU_HOLD;

  logic [width-1:0]    mem [depth];
  logic                corrupt;
  int                  wrCount = 0;
  int                  nChecks = 0;
  int                  nFail   = 0;
  int                  vCycles;
  int                  wrBase;

  rom_program_loader #(
    .width   (width),
    .depth   (depth),
    .addrBits(addrBits)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .LENGTH     (LENGTH),
    .IN_VALID   (IN_VALID),
    .IN_DATA    (IN_DATA),
    .IN_READY   (IN_READY),
    .MEM_WREN   (MEM_WREN),
    .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_DATAIN (MEM_DATAIN),
    .MEM_DATAOUT(MEM_DATAOUT),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERROR      (ERROR),
    .CPU_HOLD   (CPU_HOLD)
  );

  always #5 CLK = ~CLK;

  // Instruction store: synchronous write, registered read; address 1 can be
  // made to return its low bit flipped to model a bad readback.
  always @(posedge CLK) begin
    if (MEM_WREN) begin
      mem[MEM_ADDRESS] <= MEM_DATAIN;
      wrCount <= wrCount + 1;
    end
    if (corrupt && MEM_ADDRESS == 5'd1)
      MEM_DATAOUT <= mem[MEM_ADDRESS] ^ 9'h001;
    else
      MEM_DATAOUT <= mem[MEM_ADDRESS];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one START pulse; returns on the negedge after the sampling edge.
  task automatic applyStimulus(input logic [addrBits:0] len);
    START  = 1'b1;
    LENGTH = len;
    @(negedge CLK);
    START  = 1'b0;
  endtask

  // Present one word for one cycle and check the write it produces.
  task automatic sendWord(input logic [width-1:0] d, input logic [addrBits-1:0] addr);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    #1;
    checkOutput("wren", {31'b0, MEM_WREN}, 32'd1);
    checkOutput("waddr", {27'b0, MEM_ADDRESS}, {27'b0, addr});
    checkOutput("wdata", {23'b0, MEM_DATAIN}, {23'b0, d});
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  // Wait (bounded) for BUSY to drop, counting VERIFY cycles on the way.
  task automatic waitIdle(output int vc);
    vc = 0;
    for (int i = 0; i < 100 && BUSY; i++) begin
      if (!IN_READY) vc++;
      @(negedge CLK);
    end
    checkOutput("busyTimeout", {31'b0, BUSY}, 32'd0);
  endtask

  initial begin
    RESET    = 1'b1;
    START    = 1'b0;
    LENGTH   = '0;
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    corrupt  = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    checkOutput("rstReady", {31'b0, IN_READY}, 32'd0);
    checkOutput("rstWren", {31'b0, MEM_WREN}, 32'd0);
    checkOutput("rstAddr", {27'b0, MEM_ADDRESS}, 32'd0);
    checkOutput("rstBusy", {31'b0, BUSY}, 32'd0);
    checkOutput("rstDone", {31'b0, DONE}, 32'd0);
    checkOutput("rstError", {31'b0, ERROR}, 32'd0);
    checkOutput("rstHold", {31'b0, CPU_HOLD}, 32'd1);
    RESET = 1'b0;
    @(negedge CLK);

    // Load of three back-to-back words
    applyStimulus(6'd3);
    checkOutput("t1Ready", {31'b0, IN_READY}, 32'd1);
    checkOutput("t1Busy", {31'b0, BUSY}, 32'd1);
    sendWord(9'h005, 5'd0);
    sendWord(9'h1FF, 5'd1);
    sendWord(9'h010, 5'd2);
    checkOutput("t1Wsum", {23'b0, dut.wsum_q}, 32'h014);
    waitIdle(vCycles);
    checkOutput("t1Verify", vCycles, 32'd4);
    checkOutput("t1Done", {31'b0, DONE}, 32'd1);
    checkOutput("t1Hold", {31'b0, CPU_HOLD}, 32'd0);
    checkOutput("t1Error", {31'b0, ERROR}, 32'd0);

    // Stalled load; START from DONE re-asserts CPU_HOLD next cycle
    wrBase = wrCount;
    applyStimulus(6'd4);
    checkOutput("t2Hold", {31'b0, CPU_HOLD}, 32'd1);
    checkOutput("t2DoneDrop", {31'b0, DONE}, 32'd0);
    sendWord(9'h021, 5'd0);
    sendWord(9'h042, 5'd1);
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("t2Stall", {31'b0, MEM_WREN}, 32'd0);
      @(negedge CLK);
    end
    sendWord(9'h084, 5'd2);
    sendWord(9'h108, 5'd3);
    waitIdle(vCycles);
    checkOutput("t2Writes", wrCount - wrBase, 32'd4);
    checkOutput("t2Verify", vCycles, 32'd5);
    checkOutput("t2Done", {31'b0, DONE}, 32'd1);

    // Corrupted readback at address 1
    corrupt = 1'b1;
    applyStimulus(6'd3);
    sendWord(9'h005, 5'd0);
    sendWord(9'h1FF, 5'd1);
    sendWord(9'h010, 5'd2);
    waitIdle(vCycles);
    corrupt = 1'b0;
    checkOutput("t3Error", {31'b0, ERROR}, 32'd1);
    checkOutput("t3Done", {31'b0, DONE}, 32'd0);
    checkOutput("t3Hold", {31'b0, CPU_HOLD}, 32'd1);

    // Zero and oversize lengths
    wrBase = wrCount;
    applyStimulus(6'd0);
    checkOutput("t4ZeroDone", {31'b0, DONE}, 32'd1);
    checkOutput("t4ZeroError", {31'b0, ERROR}, 32'd0);
    checkOutput("t4ZeroHold", {31'b0, CPU_HOLD}, 32'd0);
    applyStimulus(6'd33);
    checkOutput("t4BigError", {31'b0, ERROR}, 32'd1);
    checkOutput("t4BigDone", {31'b0, DONE}, 32'd0);
    checkOutput("t4BigBusy", {31'b0, BUSY}, 32'd0);
    checkOutput("t4BigHold", {31'b0, CPU_HOLD}, 32'd1);
    repeat (2) @(negedge CLK);
    checkOutput("t4Writes", wrCount - wrBase, 32'd0);

    // Full-depth load with data = address and a stray START mid-load
    wrBase = wrCount;
    applyStimulus(6'd32);
    for (int i = 0; i < 32; i++) begin
      if (i == 10) begin
        START  = 1'b1;
        LENGTH = 6'd5;
      end
      sendWord(9'(i), 5'(i));
      START = 1'b0;
      if (i == 10) begin
        checkOutput("t5StartBusy", {31'b0, BUSY}, 32'd1);
        checkOutput("t5StartReady", {31'b0, IN_READY}, 32'd1);
      end
    end
    checkOutput("t5Wsum", {23'b0, dut.wsum_q}, 32'h1F0);
    waitIdle(vCycles);
    checkOutput("t5Writes", wrCount - wrBase, 32'd32);
    checkOutput("t5Verify", vCycles, 32'd33);
    checkOutput("t5Done", {31'b0, DONE}, 32'd1);
    checkOutput("t5Error", {31'b0, ERROR}, 32'd0);

    // Asynchronous reset in the middle of a load, then a clean reload
    applyStimulus(6'd5);
    sendWord(9'h0AA, 5'd0);
    sendWord(9'h055, 5'd1);
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("t6Busy", {31'b0, BUSY}, 32'd0);
    checkOutput("t6Ready", {31'b0, IN_READY}, 32'd0);
    checkOutput("t6Hold", {31'b0, CPU_HOLD}, 32'd1);
    checkOutput("t6Done", {31'b0, DONE}, 32'd0);
    checkOutput("t6Addr", {27'b0, MEM_ADDRESS}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    applyStimulus(6'd5);
    sendWord(9'h011, 5'd0);
    sendWord(9'h022, 5'd1);
    sendWord(9'h033, 5'd2);
    sendWord(9'h044, 5'd3);
    sendWord(9'h055, 5'd4);
    waitIdle(vCycles);
    checkOutput("t6Verify", vCycles, 32'd6);
    checkOutput("t6ReloadDone", {31'b0, DONE}, 32'd1);
    checkOutput("t6ReloadHold", {31'b0, CPU_HOLD}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
